// File: rtl/vga_pattern_pkg.sv
// Shared types and helpers for the VGA test-pattern fill engine.
package vga_pattern_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_SOLID    = 3'd0,
    MODE_VBAR     = 3'd1,
    MODE_HBAR     = 3'd2,
    MODE_CHECKER  = 3'd3,
    MODE_GRADIENT = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width for a range of v values; never narrower than one bit.
  function automatic int safe_clog2(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/vga_pattern_pixel.sv
// Combinational pixel colour for one (x, y) position of the selected pattern.
// All arithmetic wraps modulo 2**DATA_WIDTH; reserved modes fall back to solid.
module vga_pattern_pixel
  import vga_pattern_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAR_SHIFT  = 6,
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 9
) (
  input  logic [MODE_W-1:0]     fill_mode_i,
  input  logic [DATA_WIDTH-1:0] fill_base_i,
  input  logic [X_WIDTH-1:0]    x_i,
  input  logic [Y_WIDTH-1:0]    y_i,
  output logic [DATA_WIDTH-1:0] color_o
);

  logic [X_WIDTH-1:0] x_cell;
  logic [Y_WIDTH-1:0] y_cell;

  assign x_cell = x_i >> BAR_SHIFT;
  assign y_cell = y_i >> BAR_SHIFT;

  always_comb begin
    color_o = fill_base_i;
    case (fill_mode_i)
      MODE_VBAR:     color_o = fill_base_i + DATA_WIDTH'(x_cell);
      MODE_HBAR:     color_o = fill_base_i + DATA_WIDTH'(y_cell);
      MODE_CHECKER:  if (x_cell[0] ^ y_cell[0]) color_o = ~fill_base_i;
      MODE_GRADIENT: color_o = fill_base_i + DATA_WIDTH'(x_i) + DATA_WIDTH'(y_i);
      default:       color_o = fill_base_i;
    endcase
  end

endmodule

// File: rtl/vga_pattern_fill_engine.sv
// Framebuffer test-pattern writer: fills the frame on a periodic timer or a start
// pulse, streaming pixels through a valid/ready write port.
//
// Write handshake: write_signal is valid; a pixel transfers on a vga_clock edge where
// write_signal=1 and write_ready=1. While write_signal=1 and write_ready=0 the address
// and data hold, and write_signal never drops between transfers of one fill.
module vga_pattern_fill_engine
  import vga_pattern_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_WIDTH  = 8,
  parameter int PERIOD_CLKS = 8388608,
  parameter int BAR_SHIFT   = 6
) (
  input  logic                  vga_clock,
  input  logic                  reset_n,
  input  logic [MODE_W-1:0]     mode,
  input  logic                  auto_enable,
  input  logic                  start,
  input  logic                  write_ready,
  output logic                  write_signal,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic [DATA_WIDTH-1:0] base_color
);

  localparam int XW = safe_clog2(H_ACTIVE);
  localparam int YW = safe_clog2(V_ACTIVE);
  localparam int TW = safe_clog2(PERIOD_CLKS);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [TW-1:0] T_LAST = TW'(PERIOD_CLKS - 1);

  state_e                state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [DATA_WIDTH-1:0] base_q, base_d;
  logic                  pending_q, pending_d;
  logic [MODE_W-1:0]     fill_mode_q, fill_mode_d;
  logic [DATA_WIDTH-1:0] fill_base_q, fill_base_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;

  logic                  tc;
  logic                  request;
  logic                  start_fill;
  logic                  last_px;
  logic [XW-1:0]         x_inc;
  logic [YW-1:0]         y_inc;
  logic [MODE_W-1:0]     pix_mode;
  logic [DATA_WIDTH-1:0] pix_base;
  logic [XW-1:0]         pix_x;
  logic [YW-1:0]         pix_y;
  logic [DATA_WIDTH-1:0] pix_color;

  assign tc         = auto_enable && (tmr_q == T_LAST);
  assign request    = start || tc;
  assign start_fill = (state_q == ST_IDLE) && (request || pending_q);

  // Period timer and base colour; keeps running regardless of fill state.
  always_comb begin
    tmr_d  = tmr_q;
    base_d = base_q;
    if (auto_enable) begin
      if (tc) begin
        tmr_d  = '0;
        base_d = base_q + DATA_WIDTH'(1);
      end else begin
        tmr_d = tmr_q + TW'(1);
      end
    end
  end

  // Raster position of the pixel following the one currently presented.
  always_comb begin
    last_px = (x_q == X_LAST) && (y_q == Y_LAST);
    x_inc   = x_q + XW'(1);
    y_inc   = y_q;
    if (x_q == X_LAST) begin
      x_inc = '0;
      y_inc = y_q + YW'(1);
    end
  end

  // A starting fill colours pixel (0,0) from the live mode and the base about to be
  // registered, so a timer-triggered fill already uses the incremented base.
  always_comb begin
    pix_mode = fill_mode_q;
    pix_base = fill_base_q;
    pix_x    = x_inc;
    pix_y    = y_inc;
    if (start_fill) begin
      pix_mode = mode;
      pix_base = base_d;
      pix_x    = '0;
      pix_y    = '0;
    end
  end

  vga_pattern_pixel #(
    .DATA_WIDTH (DATA_WIDTH),
    .BAR_SHIFT  (BAR_SHIFT),
    .X_WIDTH    (XW),
    .Y_WIDTH    (YW)
  ) u_pixel (
    .fill_mode_i (pix_mode),
    .fill_base_i (pix_base),
    .x_i         (pix_x),
    .y_i         (pix_y),
    .color_o     (pix_color)
  );

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    fill_mode_d = fill_mode_q;
    fill_base_d = fill_base_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    data_d      = data_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_fill) begin
          state_d     = ST_FILL;
          fill_mode_d = mode;
          fill_base_d = base_d;
          x_d         = '0;
          y_d         = '0;
          addr_d      = '0;
          pending_d   = 1'b0;
          wr_d        = 1'b1;
          data_d      = pix_color;
        end
      end
      ST_FILL: begin
        if (request) pending_d = 1'b1;
        if (write_ready) begin
          if (last_px) begin
            state_d = ST_DONE;
            wr_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            x_d    = x_inc;
            y_d    = y_inc;
            addr_d = addr_q + ADDR_WIDTH'(1);
            data_d = pix_color;
          end
        end
      end
      ST_DONE: begin
        if (request) pending_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge vga_clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      base_q      <= '0;
      pending_q   <= 1'b0;
      fill_mode_q <= '0;
      fill_base_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      base_q      <= base_d;
      pending_q   <= pending_d;
      fill_mode_q <= fill_mode_d;
      fill_base_q <= fill_base_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      data_q      <= data_d;
      done_q      <= done_d;
    end
  end

  assign write_signal  = wr_q;
  assign write_address = addr_q;
  assign write_data    = data_q;
  assign busy          = (state_q != ST_IDLE);
  assign frame_done    = done_q;
  assign base_color    = base_q;

endmodule

// File: tb/tb_vga_pattern_fill_engine.sv
// Directed bench for vga_pattern_fill_engine on an 8x4 frame with a 16-cycle period.
module tb_vga_pattern_fill_engine;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int N  = H * V;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int P  = 16;
  localparam int SH = 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic          auto_enable = 1'b0;
  logic          start = 1'b0;
  logic          write_ready = 1'b0;
  logic          write_signal;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          busy;
  logic          frame_done;
  logic [DW-1:0] base_color;

  always #5 clk = ~clk;

  vga_pattern_fill_engine #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .PERIOD_CLKS (P),
    .BAR_SHIFT   (SH)
  ) dut (
    .vga_clock     (clk),
    .reset_n       (reset_n),
    .mode          (mode),
    .auto_enable   (auto_enable),
    .start         (start),
    .write_ready   (write_ready),
    .write_signal  (write_signal),
    .write_address (write_address),
    .write_data    (write_data),
    .busy          (busy),
    .frame_done    (frame_done),
    .base_color    (base_color)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int xfer_cnt = 0;
  logic [AW+DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Pattern colour from the raster position of a linear address.
  function automatic logic [DW-1:0] exp_pixel(input int m, input logic [DW-1:0] b, input int a);
    int x, y, cx, cy, r;
    x  = a % H;
    y  = a / H;
    cx = x / (1 << SH);
    cy = y / (1 << SH);
    r  = int'(b);
    case (m)
      1: r = r + cx;
      2: r = r + cy;
      3: if (((cx ^ cy) % 2) == 1) r = int'(~b);
      4: r = r + x + y;
      default: r = int'(b);
    endcase
    return r[DW-1:0];
  endfunction

  // ---------------- scoreboard / model ----------------
  logic [DW-1:0]    m_base = '0;
  int               m_tmr = 0;
  logic             rst_seen = 1'b0;
  logic             final_prev = 1'b0;
  logic             stall_prev = 1'b0;
  logic [AW-1:0]    hold_addr = '0;
  logic [DW-1:0]    hold_data = '0;
  logic [AW+DW-1:0] e;

  always @(negedge clk) begin
    check("base_color", base_color, m_base);
    check("frame_done", frame_done, final_prev);
    check("busy", busy, write_signal || frame_done);
    if (final_prev) check("ws_in_done", write_signal, 0);
    if (rst_seen) begin
      check("rst_ws", write_signal, 0);
      check("rst_addr", write_address, 0);
      check("rst_data", write_data, 0);
    end
    if (stall_prev) begin
      check("ws_held", write_signal, 1);
      check("addr_held", write_address, hold_addr);
      check("data_held", write_data, hold_data);
    end
    final_prev = 1'b0;
    stall_prev = 1'b0;
    if (reset_n && write_signal) begin
      if (write_ready) begin
        xfer_cnt++;
        check("xfer_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", write_address, e[AW+DW-1:DW]);
          check("wr_data", write_data, e[DW-1:0]);
          if (int'(e[AW+DW-1:DW]) == N - 1) final_prev = 1'b1;
        end
      end else begin
        stall_prev = 1'b1;
        hold_addr  = write_address;
        hold_data  = write_data;
      end
    end
    rst_seen = !reset_n;
    if (!reset_n) begin
      m_tmr  = 0;
      m_base = '0;
    end else if (auto_enable) begin
      if (m_tmr == P - 1) begin
        m_tmr  = 0;
        m_base = m_base + 1'b1;
      end else begin
        m_tmr++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_fill(input int m, input logic [DW-1:0] b, input int cnt);
    for (int a = 0; a < cnt; a++) exp_q.push_back({AW'(a), exp_pixel(m, b, a)});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int got = 0;
    int c   = 0;
    while (got < n && c < budget) begin
      @(negedge clk);
      if (frame_done) got++;
      c++;
    end
    check("frames_seen", got, n);
    step(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0t, expected < 1000000", $time);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat, c, x0;
    bit seen;

    check("pin_vbar_x3", exp_pixel(1, 8'h01, 3), 8'h02);
    check("pin_vbar_x7", exp_pixel(1, 8'h01, 15), 8'h04);
    check("pin_hbar_y2", exp_pixel(2, 8'h00, 17), 8'h01);
    check("pin_chk_a9", exp_pixel(3, 8'h01, 9), 8'h01);
    check("pin_chk_a10", exp_pixel(3, 8'h01, 10), 8'hFE);
    check("pin_grad_a31", exp_pixel(4, 8'hFE, 31), 8'h08);

    // Test 1: reset, then timer-driven solid fill at base 1
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ws", write_signal, 0);
    check("reset_busy", busy, 0);
    check("reset_fd", frame_done, 0);
    check("reset_base", base_color, 0);
    @(posedge clk); #1;
    push_fill(0, 8'h01, N);
    reset_n = 1'b1; auto_enable = 1'b1; mode = 3'd0; write_ready = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("t1_base_before_tc", base_color, 8'h00);
    @(negedge clk);
    check("t1_base_after_tc", base_color, 8'h01);
    check("t1_ws_first", write_signal, 1);
    check("t1_addr_first", write_address, 0);
    check("t1_data_first", write_data, 8'h01);
    lat = write_signal ? 1 : 0;
    step(1);
    auto_enable = 1'b0;
    c = 0;
    @(negedge clk);
    while (!frame_done && c < 100) begin
      if (write_signal) lat++;
      @(negedge clk);
      c++;
    end
    check("t1_fill_latency", lat, N);
    step(5);
    check("t1_ws_after", write_signal, 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // Test 2: start pulse, vertical bars, base unchanged
    mode = 3'd1;
    push_fill(1, 8'h01, N);
    pulse_start();
    wait_frames(1, 200);
    check("t2_base", base_color, 8'h01);
    check("t2_queue_empty", exp_q.size(), 0);

    // Test 3: checker under random backpressure
    mode = 3'd3;
    push_fill(3, 8'h01, N);
    x0 = xfer_cnt;
    pulse_start();
    seen = 1'b0;
    c = 0;
    while (!seen && c < 400) begin
      write_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (frame_done) seen = 1'b1;
      c++;
      step(1);
    end
    write_ready = 1'b1;
    check("t3_done", seen, 1);
    check("t3_xfers", xfer_cnt - x0, N);

    // Test 4: requests during a fill collapse into one follow-on fill
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    mode = 3'd2;
    push_fill(2, 8'h00, N);
    push_fill(1, 8'h01, N);
    pulse_start();
    step(3);
    pulse_start();
    step(2);
    pulse_start();
    mode = 3'd1;
    auto_enable = 1'b1;
    step(16);
    auto_enable = 1'b0;
    wait_frames(2, 300);
    step(40);
    check("t4_queue_empty", exp_q.size(), 0);
    check("t4_ws_idle", write_signal, 0);
    check("t4_busy_idle", busy, 0);
    check("t4_base", base_color, 8'h01);

    // Test 5: reset aborts a fill at address 13
    mode = 3'd0;
    push_fill(0, 8'h01, 13);
    pulse_start();
    seen = 1'b0;
    c = 0;
    while (!seen && c < 100) begin
      @(negedge clk);
      if (write_signal && write_address == 12) seen = 1'b1;
      c++;
    end
    check("t5_reach12", seen, 1);
    step(1);
    check("t5_addr13", write_address, 13);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_ws", write_signal, 0);
    check("t5_busy", busy, 0);
    check("t5_base", base_color, 0);
    step(1);
    reset_n = 1'b1;
    step(40);
    check("t5_queue_empty", exp_q.size(), 0);
    check("t5_ws_idle", write_signal, 0);

    // Test 6: gradient at base 0xFE and base wrap 0xFF -> 0x00
    mode = 3'd4;
    write_ready = 1'b0;
    auto_enable = 1'b1;
    step(254 * 16);
    auto_enable = 1'b0;
    check("t6_base_fe", base_color, 8'hFE);
    push_fill(4, 8'h01, N);
    push_fill(4, 8'hFE, N);
    write_ready = 1'b1;
    wait_frames(2, 300);
    check("t6_queue_a", exp_q.size(), 0);
    push_fill(4, 8'hFF, N);
    push_fill(4, 8'h00, N);
    auto_enable = 1'b1;
    step(16);
    check("t6_base_ff", base_color, 8'hFF);
    step(16);
    auto_enable = 1'b0;
    check("t6_base_wrap", base_color, 8'h00);
    wait_frames(2, 300);
    step(20);
    check("t6_queue_b", exp_q.size(), 0);
    check("t6_ws_idle", write_signal, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/vga_pattern_fill_engine.md
Name: vga_pattern_fill_engine

Overview:
- Parametrised multi-mode framebuffer test-pattern writer for the silicon shell VGA path.
- Fills the whole framebuffer with one of several selectable patterns, either on a periodic timer or on a software start pulse.
- Drives a valid/ready write port into the framebuffer arbiter, so it tolerates backpressure.
- Replaces the single-colour incrementing fill generator.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
ADDR_WIDTH, 19, framebuffer address width; must satisfy H_ACTIVE*V_ACTIVE <= 2**ADDR_WIDTH
DATA_WIDTH, 8, pixel colour width
PERIOD_CLKS, 8388608, vga_clock cycles between automatic refills (~1/3 s at 25 MHz)
BAR_SHIFT, 6, log2 of bar/checker cell size in pixels

Ports:
vga_clock  in  1  clock; also used as the write clock
reset_n  in  1  synchronous, active-low reset
mode  in  3  pattern select, latched at fill start
auto_enable  in  1  1 = periodic refill timer runs
start  in  1  single-cycle pulse; requests a fill using the current base colour
write_ready  in  1  framebuffer accepts write this cycle
write_signal  out  1  write valid
write_address  out  ADDR_WIDTH  linear pixel address, y*H_ACTIVE+x
write_data  out  DATA_WIDTH  pixel colour
busy  out  1  fill in progress
frame_done  out  1  one-cycle pulse after last pixel accepted
base_color  out  DATA_WIDTH  current base colour

Behaviour:
- Reset (sampled on the vga_clock edge while reset_n=0):
  - All outputs 0; state IDLE.
  - Period counter, x, y, base and pending flag cleared.
  - Reset mid-fill aborts immediately; no further writes.
- Period timer:
  - Counts 0..PERIOD_CLKS-1 while auto_enable=1 and holds its value while 0.
  - On the terminal count it wraps to 0, base_color <= base_color+1 (mod 2**DATA_WIDTH), and a fill request is raised.
  - The timer keeps running during a fill.
- Requests:
  - Either a start pulse or a timer terminal count is a request.
  - Both in the same cycle count as one request.
  - A request during FILL sets the pending flag (one deep; further requests merge into it).
- FSM IDLE -> FILL -> DONE -> IDLE:
  - IDLE: on a request or pending=1, go to FILL next cycle.
    - Latch mode and base_color into fill_mode/fill_base.
    - Clear x, y and address; clear pending.
    - Assert write_signal.
  - FILL: write_signal=1 with address and data stable until write_ready=1 at a clock edge (the transfer).
    - On a transfer: x+1; at x=H_ACTIVE-1, x<=0 and y+1; address+1. The address is incremental, with no multiplier.
    - The transfer with x=H_ACTIVE-1 and y=V_ACTIVE-1 moves to DONE; write_signal<=0.
    - write_signal never drops between transfers inside a fill.
  - DONE: frame_done=1 for exactly one cycle, then IDLE. If pending=1, the next fill starts from IDLE on the following cycle.
- busy=1 in FILL and DONE.
- Pixel function on fill_base (B), x and y; all arithmetic is truncated mod 2**DATA_WIDTH:
  - 0 solid: B
  - 1 vertical bars: B + (x>>BAR_SHIFT)
  - 2 horizontal bars: B + (y>>BAR_SHIFT)
  - 3 checker: ((x>>BAR_SHIFT)^(y>>BAR_SHIFT))[0] ? ~B : B
  - 4 gradient: B + x + y
  - 5–7 reserved: B
- write_data is registered alongside write_address (same-cycle alignment, no extra latency).
- Total fill latency with write_ready held at 1: H_ACTIVE*V_ACTIVE cycles of write_signal, plus 1 DONE cycle.
- Changing mode during a fill has no effect until the next fill.

Decomposition:
- Package vga_pattern_pkg:
  - Mode enum: MODE_SOLID, MODE_VBAR, MODE_HBAR, MODE_CHECKER, MODE_GRADIENT.
  - State enum: ST_IDLE, ST_FILL, ST_DONE.
  - Mode width constant.
- One sub-module, vga_pattern_pixel: combinational pixel function (fill_mode, fill_base, x, y -> colour). Parameterised by DATA_WIDTH and BAR_SHIFT, so it can be unit-tested separately.

Test Plan (bench params H_ACTIVE=8, V_ACTIVE=4, PERIOD_CLKS=16, BAR_SHIFT=1, DATA_WIDTH=8):
1. Reset release, auto_enable=1, mode=0, write_ready=1 -> after 16 cycles base_color=1; 32 consecutive writes at addresses 0..31, all data 0x01; frame_done pulses once; write_signal=0 afterwards.
2. start pulse in IDLE, auto_enable=0, mode=1 -> 32 writes; data at x=0..7 is B+0,0,1,1,2,2,3,3 on every line; base_color unchanged.
3. Mode 3, write_ready toggling 1/0 randomly -> address and data hold while write_ready=0; exactly 32 transfers; address 9 (x=1, y=1) carries B and address 10 (x=2, y=1) carries ~B.
4. start pulsed twice during a fill, plus a timer terminal count -> exactly one extra fill follows DONE; no third fill.
5. reset_n=0 asserted at address 13 mid-fill -> next cycle write_signal=0, busy=0, base_color=0; no writes until the next request.
6. Mode 4 with base 0xFE, plus timer wrap at base 0xFF -> pixel (7,3) data = 0xFE+10 = 0x08 (mod 256); base_color wraps 0xFF -> 0x00.
